// File: rtl/cache_lookup_ctrl.sv
// Hit/miss controller for a 4-way set-associative cache: set lookup, tag compare,
// refill from memory into a first-invalid / tree-PLRU victim way.
module cache_lookup_ctrl #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 8,
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req_valid,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    output logic              cpu_req_ready,
    output logic              cpu_resp_valid,
    output logic [DATA_W-1:0] cpu_resp_data,
    output logic              cpu_resp_hit,
    output logic              arr_op,
    output logic [ADDR_W-1:0] arr_addr,
    output logic [1:0]        arr_way,
    output logic [DATA_W-1:0] arr_wdata,
    input  logic [TAG_W-1:0]  arr_tag0,
    input  logic [TAG_W-1:0]  arr_tag1,
    input  logic [TAG_W-1:0]  arr_tag2,
    input  logic [TAG_W-1:0]  arr_tag3,
    input  logic              arr_valid0,
    input  logic              arr_valid1,
    input  logic              arr_valid2,
    input  logic              arr_valid3,
    input  logic [DATA_W-1:0] arr_data0,
    input  logic [DATA_W-1:0] arr_data1,
    input  logic [DATA_W-1:0] arr_data2,
    input  logic [DATA_W-1:0] arr_data3,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
);

    localparam int unsigned SETS  = 32'(1) << IDX_W;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_COMPARE, S_MISS_REQ, S_MISS_WAIT, S_FILL, S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                req_ready_q, req_ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_data_q, resp_data_d;
    logic                resp_hit_q, resp_hit_d;
    logic                arr_op_q, arr_op_d;
    logic [1:0]          arr_way_q, arr_way_d;
    logic [DATA_W-1:0]   arr_wdata_q, arr_wdata_d;
    logic                mem_req_valid_q, mem_req_valid_d;
    logic [ADDR_W-1:0]   mem_req_addr_q, mem_req_addr_d;
    logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;
    logic [1:0]          victim_q, victim_d;
    logic [2:0]          plru_q [SETS];

    logic [TAG_W-1:0]    tag_c;
    logic [IDX_W-1:0]    idx_c;
    logic [3:0]          hit_vec_c;
    logic [1:0]          hit_way_c;
    logic [DATA_W-1:0]   hit_data_c;
    logic [1:0]          victim_c;
    logic [2:0]          plru_cur_c;
    logic                plru_we_c;
    logic [1:0]          plru_way_c;

    // Tree PLRU: b0 selects the half to evict next, b1/b2 the way inside each half.
    function automatic logic [2:0] plru_next(input logic [2:0] p, input logic [1:0] w);
        logic [2:0] r;
        r = p;
        case (w)
            2'd0:    begin r[0] = 1'b1; r[1] = 1'b1; end
            2'd1:    begin r[0] = 1'b1; r[1] = 1'b0; end
            2'd2:    begin r[0] = 1'b0; r[2] = 1'b1; end
            default: begin r[0] = 1'b0; r[2] = 1'b0; end
        endcase
        return r;
    endfunction

    assign tag_c      = addr_q[ADDR_W-1:IDX_W+2];
    assign idx_c      = addr_q[IDX_W+1:2];
    assign plru_cur_c = plru_q[idx_c];
    assign hit_vec_c  = {arr_valid3 & (arr_tag3 == tag_c),
                         arr_valid2 & (arr_tag2 == tag_c),
                         arr_valid1 & (arr_tag1 == tag_c),
                         arr_valid0 & (arr_tag0 == tag_c)};

    // Lowest-index hitting way wins.
    always_comb begin
        hit_way_c  = 2'd0;
        hit_data_c = arr_data0;
        if (hit_vec_c[0]) begin
            hit_way_c  = 2'd0;
            hit_data_c = arr_data0;
        end else if (hit_vec_c[1]) begin
            hit_way_c  = 2'd1;
            hit_data_c = arr_data1;
        end else if (hit_vec_c[2]) begin
            hit_way_c  = 2'd2;
            hit_data_c = arr_data2;
        end else if (hit_vec_c[3]) begin
            hit_way_c  = 2'd3;
            hit_data_c = arr_data3;
        end
    end

    // Victim: first invalid way, otherwise follow the PLRU tree.
    always_comb begin
        victim_c = 2'd0;
        if (!arr_valid0)         victim_c = 2'd0;
        else if (!arr_valid1)    victim_c = 2'd1;
        else if (!arr_valid2)    victim_c = 2'd2;
        else if (!arr_valid3)    victim_c = 2'd3;
        else if (!plru_cur_c[0]) victim_c = plru_cur_c[1] ? 2'd1 : 2'd0;
        else                     victim_c = plru_cur_c[2] ? 2'd3 : 2'd2;
    end

    // Next state and next values of all registered outputs.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        resp_data_d    = resp_data_q;
        resp_hit_d     = resp_hit_q;
        arr_way_d      = arr_way_q;
        arr_wdata_d    = arr_wdata_q;
        mem_req_addr_d = mem_req_addr_q;
        hit_cnt_d      = hit_cnt_q;
        miss_cnt_d     = miss_cnt_q;
        victim_d       = victim_q;
        plru_we_c      = 1'b0;
        plru_way_c     = hit_way_c;

        case (state_q)
            S_IDLE: begin
                if (cpu_req_valid) begin
                    addr_d  = cpu_req_addr;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: state_d = S_COMPARE;
            S_COMPARE: begin
                if (|hit_vec_c) begin
                    resp_data_d = hit_data_c;
                    resp_hit_d  = 1'b1;
                    plru_we_c   = 1'b1;
                    plru_way_c  = hit_way_c;
                    if (hit_cnt_q != {CNT_W{1'b1}}) hit_cnt_d = hit_cnt_q + CNT_W'(1);
                    state_d     = S_RESP;
                end else begin
                    victim_d       = victim_c;
                    mem_req_addr_d = {addr_q[ADDR_W-1:2], 2'b00};
                    if (miss_cnt_q != {CNT_W{1'b1}}) miss_cnt_d = miss_cnt_q + CNT_W'(1);
                    state_d        = S_MISS_REQ;
                end
            end
            S_MISS_REQ: begin
                if (mem_req_ready) state_d = S_MISS_WAIT;
            end
            S_MISS_WAIT: begin
                if (mem_resp_valid) begin
                    arr_wdata_d = mem_resp_data;
                    arr_way_d   = victim_q;
                    state_d     = S_FILL;
                end
            end
            S_FILL: begin
                plru_we_c   = 1'b1;
                plru_way_c  = victim_q;
                resp_data_d = arr_wdata_q;
                resp_hit_d  = 1'b0;
                state_d     = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        req_ready_d     = (state_d == S_IDLE);
        resp_valid_d    = (state_d == S_RESP);
        arr_op_d        = (state_d == S_FILL);
        mem_req_valid_d = (state_d == S_MISS_REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            req_ready_q     <= 1'b1;
            resp_valid_q    <= 1'b0;
            resp_data_q     <= '0;
            resp_hit_q      <= 1'b0;
            arr_op_q        <= 1'b0;
            arr_way_q       <= '0;
            arr_wdata_q     <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            hit_cnt_q       <= '0;
            miss_cnt_q      <= '0;
            victim_q        <= '0;
            for (int unsigned s = 0; s < SETS; s++) plru_q[s] <= '0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            req_ready_q     <= req_ready_d;
            resp_valid_q    <= resp_valid_d;
            resp_data_q     <= resp_data_d;
            resp_hit_q      <= resp_hit_d;
            arr_op_q        <= arr_op_d;
            arr_way_q       <= arr_way_d;
            arr_wdata_q     <= arr_wdata_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_addr_q  <= mem_req_addr_d;
            hit_cnt_q       <= hit_cnt_d;
            miss_cnt_q      <= miss_cnt_d;
            victim_q        <= victim_d;
            if (plru_we_c) plru_q[idx_c] <= plru_next(plru_cur_c, plru_way_c);
        end
    end

    assign cpu_req_ready  = req_ready_q;
    assign cpu_resp_valid = resp_valid_q;
    assign cpu_resp_data  = resp_data_q;
    assign cpu_resp_hit   = resp_hit_q;
    assign arr_op         = arr_op_q;
    assign arr_addr       = addr_q;
    assign arr_way        = arr_way_q;
    assign arr_wdata      = arr_wdata_q;
    assign mem_req_valid  = mem_req_valid_q;
    assign mem_req_addr   = mem_req_addr_q;
    assign hit_count      = hit_cnt_q;
    assign miss_count     = miss_cnt_q;

endmodule

// File: tb/tb_cache_lookup_ctrl.sv
// Bench for cache_lookup_ctrl: behavioural array and memory models, table of
// requests checked through a response scoreboard, plus reset/backpressure sequences.
module tb_cache_lookup_ctrl;

    localparam int unsigned TAG_W = 22;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req_valid;
    logic [31:0] cpu_req_addr;
    logic        cpu_req_ready, cpu_resp_valid, cpu_resp_hit;
    logic [31:0] cpu_resp_data;
    logic        arr_op;
    logic [31:0] arr_addr, arr_wdata;
    logic [1:0]  arr_way;
    logic [TAG_W-1:0] arr_tag0, arr_tag1, arr_tag2, arr_tag3;
    logic        arr_valid0, arr_valid1, arr_valid2, arr_valid3;
    logic [31:0] arr_data0, arr_data1, arr_data2, arr_data3;
    logic        mem_req_valid, mem_req_ready, mem_resp_valid;
    logic [31:0] mem_req_addr, mem_resp_data;
    logic [15:0] hit_count, miss_count;

    always #5 clk = ~clk;

    cache_lookup_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_valid(cpu_req_valid), .cpu_req_addr(cpu_req_addr), .cpu_req_ready(cpu_req_ready),
        .cpu_resp_valid(cpu_resp_valid), .cpu_resp_data(cpu_resp_data), .cpu_resp_hit(cpu_resp_hit),
        .arr_op(arr_op), .arr_addr(arr_addr), .arr_way(arr_way), .arr_wdata(arr_wdata),
        .arr_tag0(arr_tag0), .arr_tag1(arr_tag1), .arr_tag2(arr_tag2), .arr_tag3(arr_tag3),
        .arr_valid0(arr_valid0), .arr_valid1(arr_valid1), .arr_valid2(arr_valid2), .arr_valid3(arr_valid3),
        .arr_data0(arr_data0), .arr_data1(arr_data1), .arr_data2(arr_data2), .arr_data3(arr_data3),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int exp_hits = 0;
    int exp_miss = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'h5A5A_A5A5;
    endfunction

    // Array model: registered read of the set on arr_op=0, way write on arr_op=1.
    logic [TAG_W-1:0] m_tag  [4][256];
    logic             m_val  [4][256];
    logic [31:0]      m_data [4][256];
    logic             clr_all, pl_en;
    logic [1:0]       pl_way;
    logic [7:0]       pl_idx;
    logic [TAG_W-1:0] pl_tag;
    logic [31:0]      pl_data;
    wire  [7:0]       ridx = arr_addr[9:2];

    always @(posedge clk) begin
        if (clr_all)
            for (int w = 0; w < 4; w++)
                for (int i = 0; i < 256; i++) m_val[w][i] <= 1'b0;
        if (pl_en) begin
            m_tag[pl_way][pl_idx]  <= pl_tag;
            m_val[pl_way][pl_idx]  <= 1'b1;
            m_data[pl_way][pl_idx] <= pl_data;
        end
        if (arr_op) begin
            m_tag[arr_way][ridx]  <= arr_addr[31:10];
            m_val[arr_way][ridx]  <= 1'b1;
            m_data[arr_way][ridx] <= arr_wdata;
        end else begin
            arr_tag0 <= m_tag[0][ridx]; arr_valid0 <= m_val[0][ridx]; arr_data0 <= m_data[0][ridx];
            arr_tag1 <= m_tag[1][ridx]; arr_valid1 <= m_val[1][ridx]; arr_data1 <= m_data[1][ridx];
            arr_tag2 <= m_tag[2][ridx]; arr_valid2 <= m_val[2][ridx]; arr_data2 <= m_data[2][ridx];
            arr_tag3 <= m_tag[3][ridx]; arr_valid3 <= m_val[3][ridx]; arr_data3 <= m_data[3][ridx];
        end
    end

    // Memory model: auto responder with configurable ready/response delays, or manual drive.
    logic        cfg_auto, cfg_fixed_en;
    int          cfg_rdy_dly, cfg_rsp_dly;
    logic [31:0] cfg_fixed_data;
    logic        a_ready, a_rv, man_ready, man_rv;
    logic [31:0] a_rd, man_rd;

    assign mem_req_ready  = cfg_auto ? a_ready : man_ready;
    assign mem_resp_valid = cfg_auto ? a_rv    : man_rv;
    assign mem_resp_data  = cfg_auto ? a_rd    : man_rd;

    initial begin
        logic        rsp_pend;
        int          rdy_cnt, rsp_cnt;
        logic [31:0] rsp_addr;
        a_ready = 0; a_rv = 0; a_rd = 0;
        rsp_pend = 0; rdy_cnt = 0; rsp_cnt = 0; rsp_addr = 0;
        forever begin
            @(negedge clk);
            a_rv = 0;
            if (!cfg_auto || !rst_n) begin
                a_ready = 0; rsp_pend = 0; rdy_cnt = 0;
            end else begin
                if (a_ready) begin
                    a_ready  = 0;
                    rsp_pend = 1;
                    rsp_cnt  = cfg_rsp_dly;
                    rdy_cnt  = 0;
                    rsp_addr = mem_req_addr;
                end
                if (rsp_pend) begin
                    if (rsp_cnt == 0) begin
                        a_rv     = 1;
                        a_rd     = cfg_fixed_en ? cfg_fixed_data : mem_fn(rsp_addr);
                        rsp_pend = 0;
                    end else rsp_cnt--;
                end else if (mem_req_valid) begin
                    if (rdy_cnt >= cfg_rdy_dly) a_ready = 1;
                    else rdy_cnt++;
                end
            end
        end
    end

    // Scoreboard: expected responses queued at request time, popped on cpu_resp_valid.
    typedef struct {
        logic [31:0] data;
        logic        hit;
        logic [1:0]  way;
    } exp_t;
    exp_t sb[$];
    int   fill_cycles = 0;
    logic [1:0] last_fill_way = 2'd0;

    initial forever begin
        @(negedge clk);
        if (!rst_n) fill_cycles = 0;
        else begin
            if (arr_op) begin
                fill_cycles++;
                last_fill_way = arr_way;
            end
            if (cpu_resp_valid) begin
                if (sb.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_data", cpu_resp_data, e.data);
                    chk("resp_hit", 32'(cpu_resp_hit), 32'(e.hit));
                    if (e.hit) chk("fill_on_hit", 32'(fill_cycles), 32'd0);
                    else begin
                        chk("fill_cycles", 32'(fill_cycles), 32'd1);
                        chk("fill_way", 32'(last_fill_way), 32'(e.way));
                    end
                end
                fill_cycles = 0;
            end
        end
    end

    task automatic preload(input int way, input int idx, input int tag, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1; pl_way = 2'(way); pl_idx = 8'(idx); pl_tag = TAG_W'(tag); pl_data = d;
        @(negedge clk);
        pl_en = 0;
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 50 && !cpu_req_ready; k++) @(negedge clk);
        chk("req_ready_wait", 32'(cpu_req_ready), 32'd1);
    endtask

    // Drive one request (at a negedge) and track it until the response strobe.
    task automatic do_req(input logic [31:0] addr, input logic [31:0] d, input logic hit, input logic [1:0] way);
        exp_t e;
        int n;
        logic done, saw;
        logic [31:0] maddr;
        wait_ready();
        e.data = d; e.hit = hit; e.way = way;
        sb.push_back(e);
        cpu_req_valid = 1; cpu_req_addr = addr;
        @(posedge clk);
        @(negedge clk);
        cpu_req_valid = 0;
        n = 0; done = 0; saw = 0; maddr = 0;
        for (int k = 0; k < 300 && !done; k++) begin
            if (mem_req_valid && !saw) begin saw = 1; maddr = mem_req_addr; end
            if (cpu_resp_valid) done = 1;
            else begin
                @(posedge clk); n++;
                @(negedge clk);
            end
        end
        chk("resp_arrived", 32'(done), 32'd1);
        if (hit) begin
            chk("hit_latency", 32'(n), 32'd2);
            chk("mem_req_on_hit", 32'(saw), 32'd0);
            exp_hits++;
        end else begin
            chk("mem_req_seen", 32'(saw), 32'd1);
            chk("mem_req_addr", maddr, {addr[31:2], 2'b00});
            exp_miss++;
        end
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_req_ready"}, 32'(cpu_req_ready), 32'd1);
        chk({tag, "_resp_valid"}, 32'(cpu_resp_valid), 32'd0);
        chk({tag, "_mem_req_valid"}, 32'(mem_req_valid), 32'd0);
        chk({tag, "_arr_op"}, 32'(arr_op), 32'd0);
        chk({tag, "_hit_count"}, 32'(hit_count), 32'd0);
        chk({tag, "_miss_count"}, 32'(miss_count), 32'd0);
        chk({tag, "_resp_data"}, cpu_resp_data, 32'd0);
        chk({tag, "_mem_req_addr"}, mem_req_addr, 32'd0);
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_hit_count"}, 32'(hit_count), 32'(exp_hits));
        chk({tag, "_miss_count"}, 32'(miss_count), 32'(exp_miss));
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        hit;
        logic [1:0]  way;
    } vec_t;
    vec_t vecs[11];

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic ok;
        rst_n = 0; cpu_req_valid = 0; cpu_req_addr = 0;
        man_ready = 0; man_rv = 0; man_rd = 0;
        cfg_auto = 1; cfg_fixed_en = 0; cfg_fixed_data = 0; cfg_rdy_dly = 0; cfg_rsp_dly = 0;
        pl_en = 0; pl_way = 0; pl_idx = 0; pl_tag = 0; pl_data = 0; clr_all = 1;

        vecs[0]  = '{32'd10280,     32'd2000,             1'b1, 2'd0};
        vecs[1]  = '{32'd12328,     32'd3000,             1'b1, 2'd0};
        vecs[2]  = '{32'd11304,     32'd1000,             1'b1, 2'd0};
        vecs[3]  = '{32'd101416,    mem_fn(32'd101416),   1'b0, 2'd3};
        vecs[4]  = '{32'd101417,    mem_fn(32'd101416),   1'b1, 2'd0};
        vecs[5]  = '{32'd13352,     mem_fn(32'd13352),    1'b0, 2'd0};
        vecs[6]  = '{32'd7328,      32'h0000_4001,        1'b1, 2'd0};
        vecs[7]  = '{32'd1044,      mem_fn(32'd1044),     1'b0, 2'd0};
        vecs[8]  = '{32'd2068,      mem_fn(32'd2068),     1'b0, 2'd1};
        vecs[9]  = '{32'hFFFF_FFFF, mem_fn(32'hFFFF_FFFF), 1'b0, 2'd0};
        vecs[10] = '{32'hFFFF_FFFE, mem_fn(32'hFFFF_FFFC), 1'b1, 2'd0};

        @(negedge clk);
        clr_all = 0;
        preload(1, 10, 11, 32'd1000);
        preload(1, 40, 7, 32'h0000_4001);
        preload(2, 40, 7, 32'h0000_4002);
        check_reset_outs("por");
        rst_n = 1;
        @(negedge clk);

        // Single hit: set 10 way 1, tag 11
        do_req(32'd11304, 32'd1000, 1'b1, 2'd0);
        check_counts("hit1");

        // Cold miss with delayed memory handshake and response
        cfg_rdy_dly = 2; cfg_rsp_dly = 3; cfg_fixed_en = 1; cfg_fixed_data = 32'hDEAD_BEEF;
        do_req((32'd5 << 10) | (32'd20 << 2), 32'hDEAD_BEEF, 1'b0, 2'd0);
        cfg_rdy_dly = 0; cfg_rsp_dly = 0; cfg_fixed_en = 0;
        check_counts("cold");

        preload(0, 10, 10, 32'd2000);
        preload(2, 10, 12, 32'd3000);
        preload(3, 10, 13, 32'd4000);
        for (int i = 0; i < 11; i++) do_req(vecs[i].addr, vecs[i].data, vecs[i].hit, vecs[i].way);
        check_counts("table");

        // Memory backpressure: request held stable while ready is low
        cfg_auto = 0;
        wait_ready();
        a = 32'd3272;
        sb.push_back('{mem_fn(a), 1'b0, 2'd0});
        cpu_req_valid = 1; cpu_req_addr = a;
        @(posedge clk);
        @(negedge clk);
        cpu_req_valid = 0;
        ok = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            if (mem_req_valid) ok = 1; else @(negedge clk);
        end
        chk("bp_req_seen", 32'(ok), 32'd1);
        for (int k = 0; k < 10; k++) begin
            chk("bp_mem_req_valid", 32'(mem_req_valid), 32'd1);
            chk("bp_mem_req_addr", mem_req_addr, a);
            chk("bp_cpu_req_ready", 32'(cpu_req_ready), 32'd0);
            @(negedge clk);
        end
        cfg_auto = 1;
        ok = 0;
        for (int k = 0; k < 50 && !ok; k++) begin
            if (cpu_resp_valid) ok = 1; else @(negedge clk);
        end
        chk("bp_resp_arrived", 32'(ok), 32'd1);
        exp_miss++;
        check_counts("bp");

        // Reset mid-run clears counters, outputs and PLRU state
        wait_ready();
        @(negedge clk);
        rst_n = 0;
        #1;
        check_reset_outs("rst_async");
        repeat (3) @(negedge clk);
        check_reset_outs("rst_hold");
        rst_n = 1;
        exp_hits = 0; exp_miss = 0;
        @(negedge clk);
        check_reset_outs("rst_after");
        // Set 10 fully valid; cleared PLRU must evict way 0
        do_req(32'd78888, mem_fn(32'd78888), 1'b0, 2'd0);
        check_counts("plru_rst");

        // Reset while waiting for refill data; late responses must be ignored
        cfg_auto = 0;
        wait_ready();
        cpu_req_valid = 1; cpu_req_addr = (32'd4 << 10) | (32'd60 << 2);
        @(posedge clk);
        @(negedge clk);
        cpu_req_valid = 0;
        ok = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            if (mem_req_valid) ok = 1; else @(negedge clk);
        end
        chk("mw_req_seen", 32'(ok), 32'd1);
        man_ready = 1;
        @(posedge clk);
        @(negedge clk);
        man_ready = 0;
        #2 rst_n = 0;
        #1;
        chk("mw_rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("mw_rst_resp_valid", 32'(cpu_resp_valid), 32'd0);
        chk("mw_rst_req_ready", 32'(cpu_req_ready), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1;
        exp_hits = 0; exp_miss = 0;
        for (int k = 0; k < 3; k++) begin
            man_rv = 1; man_rd = 32'hBAD0_0000 + 32'(k);
            @(negedge clk);
            chk("mw_late_arr_op", 32'(arr_op), 32'd0);
            chk("mw_late_resp_valid", 32'(cpu_resp_valid), 32'd0);
        end
        man_rv = 0;
        repeat (3) begin
            @(negedge clk);
            chk("mw_idle_arr_op", 32'(arr_op), 32'd0);
            chk("mw_idle_req_ready", 32'(cpu_req_ready), 32'd1);
        end
        cfg_auto = 1;
        do_req(32'd11304, 32'd1000, 1'b1, 2'd0);
        check_counts("final");
        chk("sb_drained", 32'(sb.size()), 32'd0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
